uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 216 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Serial-to-parallel UART receiver, 8N1, LSB first. It feeds the peripheral
//   bus receive register and its status bits. The receiver holds a received
//   byte until the bus reads it. It also keeps sticky framing-error and
//   overrun flags for software diagnostics.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per bit time (>= 4)
//   CNT_W        : bit-timer width, must hold CLKS_PER_BIT-1
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-low reset
//   UART_RX    in   asynchronous serial line, idle high
//   UART_RXD   out  last received byte (register)
//   RX_EFF     out  1 = UART_RXD holds an unread byte
//   RX_READ    in   level; every high cycle marks the byte as read
//   RX_FERR    out  sticky framing error (stop bit sampled 0)
//   RX_OVERRUN out  sticky: byte completed while an unread byte was pending
//   ERR_CLR    in   clears RX_FERR and RX_OVERRUN
//   rx_busy    out  1 whenever the FSM is not idle
//
// FSM states
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge on rx_s
//   START | timing to the middle of the start bit, then confirming it
//   DATA  | sampling 8 data bits at mid-bit, LSB first
//   STOP  | sampling the stop bit, then loading or flagging
//   BREAK | stop bit was low; waiting for the line to return high
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] UART_RXD,
  output logic       RX_EFF,
  input  logic       RX_READ,
  output logic       RX_FERR,
  output logic       RX_OVERRUN,
  input  logic       ERR_CLR,
  output logic       rx_busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Terminal counts. The start bit only runs to half a bit, so every later
  // sample lands near the middle of its bit.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Synchronizer: both flops reset to the idle (high) line level.
  logic rx_meta_q;
  logic rx_s_q;

  logic [2:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;

  logic [7:0]       rxd_q,     rxd_d;
  logic             eff_q,     eff_d;
  logic             ferr_q,    ferr_d;
  logic             ovr_q,     ovr_d;

  // Single-cycle events raised by the FSM in the stop-sample cycle.
  logic stop_ok;
  logic stop_bad;
  logic load;
  logic ovr_set;

  // -------------------------------------------------------------------------
  // Next-state logic for the frame FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // The line went high again before mid-start: this was a glitch.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            stop_ok = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_BREAK: begin
        // A line held low must not be decoded as a stream of 0x00 frames.
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Receive register and status flags
  // -------------------------------------------------------------------------
  // A read in the same cycle as a completed frame frees the register in time,
  // so the new byte is accepted rather than counted as an overrun.
  assign load    = stop_ok && (!eff_q || RX_READ);
  assign ovr_set = stop_ok && eff_q && !RX_READ;

  always_comb begin
    rxd_d = rxd_q;
    eff_d = eff_q;

    if (load) begin
      rxd_d = shift_q;
      eff_d = 1'b1;
    end else if (RX_READ) begin
      eff_d = 1'b0;
    end

    // A new error event in the clear cycle wins, so no event is lost.
    ferr_d = (ferr_q && !ERR_CLR) || stop_bad;
    ovr_d  = (ovr_q  && !ERR_CLR) || ovr_set;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      rxd_q     <= 8'h00;
      eff_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= UART_RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rxd_q     <= rxd_d;
      eff_q     <= eff_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign UART_RXD   = rxd_q;
  assign RX_EFF     = eff_q;
  assign RX_FERR    = ferr_q;
  assign RX_OVERRUN = ovr_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Self-checking bench for uart_receiver at CLKS_PER_BIT=16. Expected bytes
//   are queued when a frame is sent and popped when the DUT loads a byte.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic [7:0] UART_RXD;
  logic       RX_EFF;
  logic       RX_READ;
  logic       RX_FERR;
  logic       RX_OVERRUN;
  logic       ERR_CLR;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int load_cyc = -1;
  int fall_cyc = 0;

  logic [7:0] exp_q[$];
  logic       prev_eff = 1'b0;
  logic [7:0] prev_rxd = 8'h00;

  uart_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .UART_RXD  (UART_RXD),
    .RX_EFF    (RX_EFF),
    .RX_READ   (RX_READ),
    .RX_FERR   (RX_FERR),
    .RX_OVERRUN(RX_OVERRUN),
    .ERR_CLR   (ERR_CLR),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: a load shows up as RX_EFF rising, or as a new byte
  // replacing an unread one when the read coincides with the stop sample.
  always @(negedge clk) begin
    if (reset) begin
      if (RX_EFF && (!prev_eff || UART_RXD != prev_rxd)) begin
        load_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(UART_RXD), 32'h100);
        else chk("rx_byte", 32'(UART_RXD), 32'(exp_q.pop_front()));
      end
    end
    prev_eff = RX_EFF;
    prev_rxd = UART_RXD;
  end

  // One full 8N1 frame, 10 bit times. read_at pulses RX_READ in that frame
  // cycle; rst_at asserts reset from that frame cycle to the end of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int read_at, input int rst_at);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      UART_RX = fr[i / CPB];
      RX_READ = (i == read_at);
      if (rst_at >= 0 && i >= rst_at) reset = 1'b0;
      @(negedge clk);
    end
    RX_READ = 1'b0;
    UART_RX = stop_bit;
  endtask

  task automatic idle(input int n);
    UART_RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic read_pulse();
    RX_READ = 1'b1;
    @(negedge clk);
    RX_READ = 1'b0;
  endtask

  task automatic clr_pulse();
    ERR_CLR = 1'b1;
    @(negedge clk);
    ERR_CLR = 1'b0;
  endtask

  initial begin
    logic busy_seen;
    reset   = 1'b0;
    UART_RX = 1'b1;
    RX_READ = 1'b0;
    ERR_CLR = 1'b0;

    // 1. reset state and idle line
    repeat (3) @(negedge clk);
    chk("rst_rxd",  32'(UART_RXD),   32'h00);
    chk("rst_eff",  32'(RX_EFF),     32'h0);
    chk("rst_ferr", 32'(RX_FERR),    32'h0);
    chk("rst_ovr",  32'(RX_OVERRUN), 32'h0);
    chk("rst_busy", 32'(rx_busy),    32'h0);
    reset = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    chk("idle_busy", 32'(busy_seen), 32'h0);

    // 2. single byte, latency and read
    exp_q.push_back(8'hA5);
    fall_cyc = cyc;
    load_cyc = -1;
    send_frame(8'hA5, 1'b1, -1, -1);
    idle(4);
    chk("a5_latency_ok",
        32'((load_cyc - fall_cyc >= 151) && (load_cyc - fall_cyc <= 157)), 32'h1);
    chk("a5_eff", 32'(RX_EFF), 32'h1);
    read_pulse();
    chk("a5_eff_after_read", 32'(RX_EFF), 32'h0);
    chk("a5_rxd_after_read", 32'(UART_RXD), 32'hA5);

    // 3. overrun, then read coinciding with the stop sample
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(4);
    send_frame(8'hC3, 1'b1, -1, -1);
    idle(4);
    chk("ovr_flag", 32'(RX_OVERRUN), 32'h1);
    chk("ovr_rxd",  32'(UART_RXD),   32'h3C);
    chk("ovr_eff",  32'(RX_EFF),     32'h1);
    read_pulse();
    clr_pulse();
    chk("ovr_cleared", 32'(RX_OVERRUN), 32'h0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(4);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 9 * CPB + 10, -1);
    idle(4);
    chk("rdstop_rxd", 32'(UART_RXD),   32'hC3);
    chk("rdstop_eff", 32'(RX_EFF),     32'h1);
    chk("rdstop_ovr", 32'(RX_OVERRUN), 32'h0);
    read_pulse();

    // 4. framing error and break
    send_frame(8'h55, 1'b0, -1, -1);
    UART_RX = 1'b0;
    repeat (64) @(negedge clk);
    chk("brk_ferr", 32'(RX_FERR), 32'h1);
    chk("brk_eff",  32'(RX_EFF),  32'h0);
    chk("brk_busy", 32'(rx_busy), 32'h1);
    chk("brk_ovr",  32'(RX_OVERRUN), 32'h0);
    UART_RX = 1'b1;
    repeat (2) @(negedge clk);
    chk("brk_busy_hi2", 32'(rx_busy), 32'h1);
    @(negedge clk);
    chk("brk_busy_hi3", 32'(rx_busy), 32'h0);
    clr_pulse();
    chk("ferr_cleared", 32'(RX_FERR), 32'h0);

    // 5. false start, then back-to-back 00 / FF
    UART_RX = 1'b0;
    repeat (5) @(negedge clk);
    chk("fs_busy_start", 32'(rx_busy), 32'h1);
    UART_RX = 1'b1;
    repeat (9) @(negedge clk);
    chk("fs_busy_idle", 32'(rx_busy),    32'h0);
    chk("fs_eff",       32'(RX_EFF),     32'h0);
    chk("fs_ferr",      32'(RX_FERR),    32'h0);
    chk("fs_ovr",       32'(RX_OVERRUN), 32'h0);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, -1, -1);
    read_pulse();
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, -1, -1);
    idle(2);
    chk("ff_rxd", 32'(UART_RXD), 32'hFF);
    chk("ff_eff", 32'(RX_EFF),   32'h1);

    // 6. reset during data bit 4, then a clean frame
    send_frame(8'h81, 1'b1, -1, 6 * CPB - 8);
    chk("mid_rst_rxd",  32'(UART_RXD),   32'h00);
    chk("mid_rst_eff",  32'(RX_EFF),     32'h0);
    chk("mid_rst_busy", 32'(rx_busy),    32'h0);
    chk("mid_rst_ferr", 32'(RX_FERR),    32'h0);
    chk("mid_rst_ovr",  32'(RX_OVERRUN), 32'h0);
    reset = 1'b1;
    idle(5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1, -1);
    idle(4);
    chk("post_rst_rxd", 32'(UART_RXD), 32'h81);
    chk("post_rst_eff", 32'(RX_EFF),   32'h1);

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
